csi_rx_clk_ctrl: RTL
====================

CSI_RX_CLK_CTRL -- requirements
Module: csi_rx_clk_ctrl

Interface
- REQ-001 Parameter RST_CYCLES, default 16: cycles bufr_reset is held high during bring-up.
- REQ-002 Parameter SETTLE_CYCLES, default 64: cycles waited after bufr_reset release before serdes_reset release.
- REQ-003 Parameter ACT_EDGES, default 8: consecutive toggle edges required to declare clock activity.
- REQ-004 Parameter TIMEOUT, default 256: maximum cycles between toggle edges before clock is declared lost.
- REQ-005 Parameters FREQ_WIN 1024, FREQ_MIN 200, FREQ_MAX 300: frequency-check window and edge-count limits (see Configuration).
- REQ-006 clock  in  1  free-running system clock; all logic on its rising edge.
- REQ-007 reset  in  1  synchronous, active-high reset.
- REQ-008 enable  in  1  high permits bring-up; low forces IDLE.
- REQ-009 byte_clk_tgl  in  1  toggles once per byte_clock period, asynchronous to clock.
- REQ-010 bufr_reset  out  1  drives CLR of the D-PHY clock BUFRs.
- REQ-011 serdes_reset  out  1  reset for the lane deserializers.
- REQ-012 clk_locked  out  1  high only in LOCKED.
- REQ-013 clk_lost  out  1  one-cycle pulse on LOCKED exit due to timeout or frequency fault.
- REQ-014 state  out  3  encoded current state.
- REQ-015 relock_cnt  out  8  count of clk_lost events, saturating at 255.

Function
- REQ-016 byte_clk_tgl SHALL pass through a 2-flop synchronizer plus one history flop; an edge is a mismatch between stage 2 and the history flop, detected 3 cycles after input change.
- REQ-017 States: IDLE=0, WAIT_ACT=1, BUFR_RST=2, SETTLE=3, SERDES_RST=4, LOCKED=5; codes 6-7 SHALL go to IDLE next cycle.
- REQ-018 IDLE -> WAIT_ACT when enable=1.
- REQ-019 WAIT_ACT: an edge-gap counter restarts on every edge; the edge counter clears when the gap reaches TIMEOUT; reaching ACT_EDGES edges -> BUFR_RST.
- REQ-020 BUFR_RST: bufr_reset=1 for exactly RST_CYCLES cycles, then -> SETTLE.
- REQ-021 SETTLE: bufr_reset=0, serdes_reset=1 for exactly SETTLE_CYCLES cycles, then -> SERDES_RST.
- REQ-022 SERDES_RST: serdes_reset=1 for 4 cycles, then -> LOCKED with serdes_reset=0.
- REQ-023 LOCKED: a gap of TIMEOUT cycles with no edge SHALL pulse clk_lost, increment relock_cnt, and -> WAIT_ACT.
- REQ-024 bufr_reset SHALL be 1 in IDLE, WAIT_ACT and BUFR_RST; serdes_reset SHALL be 1 in every state except LOCKED.
- REQ-025 All outputs SHALL be registered; clk_locked rises the cycle after entering LOCKED.
- REQ-026 enable=0 in any state -> IDLE next cycle, with no clk_lost pulse and relock_cnt unchanged.
- REQ-027 Timeout and enable=0 in the same cycle: enable wins.
- REQ-028 All counters SHALL be sized for their parameter and SHALL NOT wrap.

Reset
- REQ-029 reset SHALL force state=IDLE, bufr_reset=1, serdes_reset=1, clk_locked=0, clk_lost=0, relock_cnt=0, and clear all counters and synchronizer flops, taking priority over all other inputs, including mid-sequence.

Configuration
- REQ-030 With macro CSI_RX_CLK_FREQ_CHECK_EN defined: in LOCKED, edges are counted over consecutive FREQ_WIN-cycle windows; a count outside [FREQ_MIN, FREQ_MAX] at window end SHALL pulse clk_lost, increment relock_cnt, and -> WAIT_ACT; the window restarts on LOCKED entry.
- REQ-031 Without the macro: no window logic is present; only the timeout causes LOCKED exit.

Verification
- REQ-032 Toggle every 4 cycles, enable=1 -> LOCKED reached; bufr_reset high exactly 16 cycles in BUFR_RST; serdes_reset falls 68 cycles after bufr_reset falls.
- REQ-033 In LOCKED, stop toggling -> clk_lost pulses once 256 cycles after the last edge; relock_cnt=1; state=1.
- REQ-034 7 edges, then a 300-cycle gap, then 8 edges -> BUFR_RST entered only after the 8th edge of the second burst.
- REQ-035 Drop enable in SETTLE -> IDLE next cycle, bufr_reset=1, no clk_lost; reassert reset mid-BUFR_RST -> all outputs at reset values next cycle.
- REQ-036 With CSI_RX_CLK_FREQ_CHECK_EN defined, toggle every 2 cycles (512 edges/window) -> clk_lost at first window end; toggle every 4 cycles (256 edges/window) -> remains LOCKED.
- REQ-037 Force 256 loss events -> relock_cnt saturates at 255.

Source files
------------

// File: rtl/csi_rx_clk_ctrl.sv
// csi_rx_clk_ctrl
//   Bring-up and supervision of the D-PHY byte clock for a CSI-2 receiver.
//   The byte clock is observed as a toggle signal (byte_clk_tgl) that is
//   synchronised into the system clock domain. Once enough consecutive
//   toggle edges are seen, the BUFRs are held in reset, allowed to settle,
//   the deserializers are released and the block reports lock. Losing the
//   byte clock (no edge for TIMEOUT cycles) drops lock and restarts.
//
// Optional feature macro: CSI_RX_CLK_FREQ_CHECK_EN
//   When defined, the edge rate is also checked in LOCKED over consecutive
//   FREQ_WIN-cycle windows; a count outside [FREQ_MIN, FREQ_MAX] drops lock.
//
// Ports
//   clock         system clock, all logic on its rising edge
//   reset         synchronous active-high reset
//   enable        1 permits bring-up, 0 returns to IDLE
//   byte_clk_tgl  toggles once per byte clock period (asynchronous)
//   bufr_reset    CLR for the D-PHY clock BUFRs
//   serdes_reset  reset for the lane deserializers
//   clk_locked    high only in LOCKED
//   clk_lost      one-cycle pulse when LOCKED is left on a clock fault
//   state         encoded current state
//   relock_cnt    number of clk_lost events, saturating at 255
module csi_rx_clk_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int ACT_EDGES     = 8,
  parameter int TIMEOUT       = 256,
  parameter int FREQ_WIN      = 1024,
  parameter int FREQ_MIN      = 200,
  parameter int FREQ_MAX      = 300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       byte_clk_tgl,
  output logic       bufr_reset,
  output logic       serdes_reset,
  output logic       clk_locked,
  output logic       clk_lost,
  output logic [2:0] state,
  output logic [7:0] relock_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_ACT   = 3'd1,
    ST_BUFR_RST   = 3'd2,
    ST_SETTLE     = 3'd3,
    ST_SERDES_RST = 3'd4,
    ST_LOCKED     = 3'd5
  } state_t;

  localparam int SERDES_CYCLES = 4;
  localparam int PH_MAX_A      = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int PH_MAX        = (PH_MAX_A > SERDES_CYCLES) ? PH_MAX_A : SERDES_CYCLES;
  localparam int PH_W          = $clog2(PH_MAX + 1);
  localparam int GAP_W         = $clog2(TIMEOUT + 1);
  localparam int EDGE_W        = $clog2(ACT_EDGES + 1);

  localparam logic [PH_W-1:0]   RST_LAST    = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0]   SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]   SERDES_LAST = PH_W'(SERDES_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'(TIMEOUT - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST   = EDGE_W'(ACT_EDGES - 1);

  // Reject an inconsistent frequency window at elaboration in every build.
  if (FREQ_MIN > FREQ_MAX || FREQ_MAX > FREQ_WIN) begin : g_bad_freq_cfg
    $error("csi_rx_clk_ctrl: FREQ_MIN/FREQ_MAX/FREQ_WIN inconsistent");
  end

  state_t             state_reg;
  logic               bufr_reset_reg;
  logic               serdes_reset_reg;
  logic               clk_locked_reg;
  logic               clk_lost_reg;
  logic [7:0]         relock_cnt_reg;
  logic [PH_W-1:0]    phase_cnt_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic [EDGE_W-1:0]  edge_cnt_reg;
  logic               sync1_reg;
  logic               sync2_reg;
  logic               hist_reg;

  logic edge_det;
  logic timeout_hit;
  logic loss_event;

  // An edge is any change between the synchronised sample and its history.
  assign edge_det    = sync2_reg ^ hist_reg;
  // TIMEOUT consecutive cycles without an edge.
  assign timeout_hit = !edge_det && (gap_cnt_reg == GAP_LAST);

`ifdef CSI_RX_CLK_FREQ_CHECK_EN
  localparam int WIN_W = $clog2(FREQ_WIN + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(FREQ_WIN - 1);
  localparam logic [WIN_W:0]   CNT_MIN  = (WIN_W + 1)'(FREQ_MIN);
  localparam logic [WIN_W:0]   CNT_MAX  = (WIN_W + 1)'(FREQ_MAX);

  logic [WIN_W-1:0] win_cnt_reg;
  logic [WIN_W-1:0] win_edges_reg;
  logic [WIN_W:0]   win_total;
  logic             freq_fault;

  // The edge arriving on the last window cycle still belongs to that window.
  assign win_total  = {1'b0, win_edges_reg} + {{WIN_W{1'b0}}, edge_det};
  assign freq_fault = (win_cnt_reg == WIN_LAST) &&
                      ((win_total < CNT_MIN) || (win_total > CNT_MAX));
  assign loss_event = timeout_hit || freq_fault;

  // Windows run back to back while LOCKED and restart on every entry.
  always_ff @(posedge clock) begin
    if (reset || !enable || state_reg != ST_LOCKED) begin
      win_cnt_reg   <= '0;
      win_edges_reg <= '0;
    end else if (win_cnt_reg == WIN_LAST) begin
      win_cnt_reg   <= '0;
      win_edges_reg <= '0;
    end else begin
      win_cnt_reg <= win_cnt_reg + 1'b1;
      if (edge_det) win_edges_reg <= win_edges_reg + 1'b1;
    end
  end
`else
  assign loss_event = timeout_hit;
`endif

  // Outputs are registered alongside the state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      bufr_reset_reg   <= 1'b1;
      serdes_reset_reg <= 1'b1;
      clk_locked_reg   <= 1'b0;
      clk_lost_reg     <= 1'b0;
      relock_cnt_reg   <= '0;
      phase_cnt_reg    <= '0;
      gap_cnt_reg      <= '0;
      edge_cnt_reg     <= '0;
      sync1_reg        <= 1'b0;
      sync2_reg        <= 1'b0;
      hist_reg         <= 1'b0;
    end else begin
      sync1_reg    <= byte_clk_tgl;
      sync2_reg    <= sync1_reg;
      hist_reg     <= sync2_reg;
      clk_lost_reg <= 1'b0;

      if (!enable) begin
        // Takes precedence over a coincident timeout: no clk_lost, no count.
        state_reg        <= ST_IDLE;
        bufr_reset_reg   <= 1'b1;
        serdes_reset_reg <= 1'b1;
        clk_locked_reg   <= 1'b0;
        phase_cnt_reg    <= '0;
        gap_cnt_reg      <= '0;
        edge_cnt_reg     <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            state_reg     <= ST_WAIT_ACT;
            phase_cnt_reg <= '0;
            gap_cnt_reg   <= '0;
            edge_cnt_reg  <= '0;
          end
          ST_WAIT_ACT: begin
            if (edge_det) begin
              gap_cnt_reg <= '0;
              if (edge_cnt_reg == EDGE_LAST) begin
                state_reg     <= ST_BUFR_RST;
                edge_cnt_reg  <= '0;
                phase_cnt_reg <= '0;
              end else begin
                edge_cnt_reg <= edge_cnt_reg + 1'b1;
              end
            end else if (gap_cnt_reg == GAP_LAST) begin
              // Gap too long: activity must be re-proven from scratch.
              edge_cnt_reg <= '0;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
          end
          ST_BUFR_RST: begin
            if (phase_cnt_reg == RST_LAST) begin
              state_reg      <= ST_SETTLE;
              bufr_reset_reg <= 1'b0;
              phase_cnt_reg  <= '0;
            end else begin
              phase_cnt_reg <= phase_cnt_reg + 1'b1;
            end
          end
          ST_SETTLE: begin
            if (phase_cnt_reg == SETTLE_LAST) begin
              state_reg     <= ST_SERDES_RST;
              phase_cnt_reg <= '0;
            end else begin
              phase_cnt_reg <= phase_cnt_reg + 1'b1;
            end
          end
          ST_SERDES_RST: begin
            if (phase_cnt_reg == SERDES_LAST) begin
              state_reg        <= ST_LOCKED;
              serdes_reset_reg <= 1'b0;
              clk_locked_reg   <= 1'b1;
              phase_cnt_reg    <= '0;
              gap_cnt_reg      <= '0;
            end else begin
              phase_cnt_reg <= phase_cnt_reg + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (loss_event) begin
              state_reg        <= ST_WAIT_ACT;
              bufr_reset_reg   <= 1'b1;
              serdes_reset_reg <= 1'b1;
              clk_locked_reg   <= 1'b0;
              clk_lost_reg     <= 1'b1;
              gap_cnt_reg      <= '0;
              edge_cnt_reg     <= '0;
              if (relock_cnt_reg != 8'hFF) relock_cnt_reg <= relock_cnt_reg + 1'b1;
            end else if (edge_det) begin
              gap_cnt_reg <= '0;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
          end
          default: begin
            // Unused encodings recover to IDLE with safe outputs.
            state_reg        <= ST_IDLE;
            bufr_reset_reg   <= 1'b1;
            serdes_reset_reg <= 1'b1;
            clk_locked_reg   <= 1'b0;
            phase_cnt_reg    <= '0;
            gap_cnt_reg      <= '0;
            edge_cnt_reg     <= '0;
          end
        endcase
      end
    end
  end

  assign state        = state_reg;
  assign bufr_reset   = bufr_reset_reg;
  assign serdes_reset = serdes_reset_reg;
  assign clk_locked   = clk_locked_reg;
  assign clk_lost     = clk_lost_reg;
  assign relock_cnt   = relock_cnt_reg;

endmodule
